mmio_hub: RTL and testbench
===========================

Name: mmio_hub

Overview:
- Parametrised successor to the processor's memory/MMIO front end.
- Wraps the team RAM module and decodes an 8-word MMIO window. Writes to the window never reach RAM.
- Adds:
  - N debounced buttons, with level and sticky rising-edge flags.
  - A wide LED register.
  - An animation frame register with a hardware auto-advance timer that feeds the hologram renderer.

Parameters:
- ADDR_WIDTH, 12, address bits; RAM depth is 2**ADDR_WIDTH.
- MMIO_BASE, 1000, word address of MMIO offset 0; must be a multiple of 8 (base 1000 satisfies this).
- NUM_BTN, 5, number of button inputs (1..32).
- LED_WIDTH, 16, LED register width (1..32).
- FRAME_WIDTH, 8, frame index width (1..32).
- NUM_FRAMES, 64, frame count (2..2**FRAME_WIDTH).
- PERIOD_WIDTH, 24, auto-advance period counter width (1..32).
- DEBOUNCE_CYCLES, 250000, stable cycles required before a button change is accepted (>=1).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- wEn, in, 1, processor write enable.
- addr, in, ADDR_WIDTH, processor word address.
- dataIn, in, 32, processor write data.
- dataOut, out, 32, processor read data.
- btn, in, NUM_BTN, raw asynchronous button inputs.
- LED, out, LED_WIDTH, LED register.
- frame_idx, out, FRAME_WIDTH, current animation frame.
- irq, out, 1, button interrupt request (see Optional Feature).

Behaviour:
- Window decode: hit = (addr >= MMIO_BASE) && (addr < MMIO_BASE+8); off = addr - MMIO_BASE.
- RAM wEn = wEn & !hit.
- dataOut = MMIO mux when hit, else RAM output. The MMIO mux is combinational from registers, with the same read timing as RAM.
- Register map (RO = read-only, RW = read/write, W1C = write-1-to-clear; unused high bits read 0):
  - +0 BTN_STATE, RO: debounced levels.
  - +1 LED, RW: [LED_WIDTH-1:0].
  - +2 FRAME, RW: write value >= NUM_FRAMES saturates to NUM_FRAMES-1. Any write clears the period counter.
  - +3 BTN_EDGE, W1C: sticky rising-edge flags.
  - +4 FRAME_CTRL, RW: bit0 auto_en, bit1 dir (0 = increment, 1 = decrement).
  - +5 FRAME_PERIOD, RW: [PERIOD_WIDTH-1:0].
  - +6 IRQ_MASK: see Optional Feature.
  - +7: reserved, reads 0, writes ignored.
- Reset: all registers, flags, counters and synchronisers go to 0. Outputs: LED=0, frame_idx=0, irq=0, dataOut=RAM output. RAM contents are not reset.
- Button path, per bit:
  - 2-flop synchroniser feeds the debouncer.
  - If sync == stable, the debounce counter clears to 0.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, stable takes the sync value next cycle and the counter clears.
  - Latency from a clean input change to BTN_STATE is 2 + DEBOUNCE_CYCLES cycles.
- Edge flags: a stable 0->1 transition sets BTN_EDGE[i]. If a set and a W1C of the same bit occur in the same cycle, the set wins.
- Auto-advance, active when auto_en=1 and FRAME_PERIOD != 0:
  - The period counter increments each cycle; on reaching FRAME_PERIOD-1 it clears and the frame steps by one.
  - Increment wraps NUM_FRAMES-1 -> 0; decrement wraps 0 -> NUM_FRAMES-1.
- Auto-advance held (auto_en=0 or FRAME_PERIOD=0): the counter holds at 0 and the frame is static.
- A processor FRAME write in the same cycle as a step tick: the write wins and the counter clears.
- Writing FRAME_PERIOD clears the counter.
- Async reset mid-debounce or mid-period aborts immediately, with no residual flag or step.

Optional Feature:
- Macro: MMIO_IRQ_EN.
- Defined:
  - +6 IRQ_MASK is RW [NUM_BTN-1:0], reset 0.
  - irq = |(BTN_EDGE & IRQ_MASK), registered: 1 cycle after the flag is set, and low 1 cycle after the flag is cleared.
- Undefined: +6 reads 0, writes are ignored, irq is tied 0.

Test Plan:
1. Reset then reads: assert rst_n=0 mid-run, release. Read +0..+7 -> all 0. LED=0, frame_idx=0. RAM word 5 is still readable with its prior value.
2. Window isolation: write 0xABCD to addr 1001 (+1) -> LED=0xABCD, RAM[1001] unchanged. Write 0x1234 to addr 999 -> RAM[999]=0x1234.
3. Debounce and edge flags (DEBOUNCE_CYCLES=4):
   - btn[2] glitch high for 3 cycles -> BTN_STATE=0, BTN_EDGE=0.
   - Hold btn[2] high -> BTN_STATE=0x4 at cycle 6, BTN_EDGE=0x4.
   - Write 0x4 to +3 in the same cycle as a new btn[2] rising edge -> flag stays 1.
4. Auto-advance (NUM_FRAMES=4, FRAME_PERIOD=3, auto_en=1, dir=0): from 0, frame_idx goes 1,2,3,0 every 3 cycles. Set dir=1 at 0 -> next step 3.
5. Frame write conflict and saturation:
   - Write FRAME=2 on a tick cycle -> frame_idx=2, next step 3 cycles later.
   - Write FRAME=9 with NUM_FRAMES=4 -> frame_idx=3.
6. With MMIO_IRQ_EN: IRQ_MASK=0x1; btn[0] press -> irq=1 one cycle after the flag sets; W1C 0x1 -> irq=0 one cycle later. Without the macro: irq stays 0 and +6 reads 0.

Source files
------------

// File: rtl/mmio_hub.sv
// rtl/mmio_hub.sv - RAM front end with 8-word MMIO window: buttons, LEDs, animation frame timer.
// Optional MMIO_IRQ_EN adds IRQ_MASK at +6 and a registered button interrupt.
module mmio_hub_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);
    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];
endmodule

module mmio_hub #(
    parameter int ADDR_WIDTH      = 12,
    parameter int MMIO_BASE       = 1000,
    parameter int NUM_BTN         = 5,
    parameter int LED_WIDTH       = 16,
    parameter int FRAME_WIDTH     = 8,
    parameter int NUM_FRAMES      = 64,
    parameter int PERIOD_WIDTH    = 24,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wEn,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [31:0]            dataIn,
    output logic [31:0]            dataOut,
    input  logic [NUM_BTN-1:0]     btn,
    output logic [LED_WIDTH-1:0]   LED,
    output logic [FRAME_WIDTH-1:0] frame_idx,
    output logic                   irq
);
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0]         DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]            BASE       = MMIO_BASE;
    localparam logic [31:0]            BASE_END   = MMIO_BASE + 8;
    localparam logic [32:0]            NF         = 33'(NUM_FRAMES);
    localparam logic [FRAME_WIDTH-1:0] FRAME_LAST = FRAME_WIDTH'(NUM_FRAMES - 1);

    logic [31:0] addr_ext;
    logic        hit;
    logic [2:0]  off;
    logic        mmio_we;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;

    assign addr_ext = 32'(addr);
    assign hit      = (addr_ext >= BASE) && (addr_ext < BASE_END);
    assign off      = addr[2:0] - BASE[2:0];
    assign mmio_we  = wEn & hit;
    assign ram_we   = wEn & ~hit;

    mmio_hub_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr),
        .din  (dataIn),
        .dout (ram_rdata)
    );

    logic [NUM_BTN-1:0]           sync1_q, sync2_q;
    logic [NUM_BTN-1:0]           stable_q, stable_d;
    logic [NUM_BTN-1:0][DBW-1:0]  dbcnt_q, dbcnt_d;
    logic [NUM_BTN-1:0]           rise;
    logic [NUM_BTN-1:0]           edge_q, edge_d;
    logic [NUM_BTN-1:0]           w1c;
    logic [LED_WIDTH-1:0]         led_q, led_d;
    logic [FRAME_WIDTH-1:0]       frame_q, frame_d;
    logic [PERIOD_WIDTH-1:0]      period_q, period_d;
    logic [PERIOD_WIDTH-1:0]      pcnt_q, pcnt_d;
    logic                         auto_en_q, auto_en_d;
    logic                         dir_q, dir_d;
    logic                         active;
    logic                         tick;

    // A button change is accepted only after the synchronised level differs from stable long enough.
    always_comb begin
        stable_d = stable_q;
        dbcnt_d  = dbcnt_q;
        rise     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                dbcnt_d[i] = '0;
            end else if (dbcnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                dbcnt_d[i]  = '0;
                rise[i]     = sync2_q[i];
            end else begin
                dbcnt_d[i] = dbcnt_q[i] + 1'b1;
            end
        end
    end

    assign w1c    = (mmio_we && off == 3'd3) ? dataIn[NUM_BTN-1:0] : '0;
    assign edge_d = (edge_q & ~w1c) | rise;

    assign active = auto_en_q && (period_q != '0);
    assign tick   = active && (pcnt_q == period_q - PERIOD_WIDTH'(1));

    always_comb begin
        led_d     = led_q;
        period_d  = period_q;
        auto_en_d = auto_en_q;
        dir_d     = dir_q;
        frame_d   = frame_q;
        pcnt_d    = (active && !tick) ? pcnt_q + PERIOD_WIDTH'(1) : '0;
        if (tick) begin
            if (!dir_q) begin
                frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_WIDTH'(1);
            end else begin
                frame_d = (frame_q == '0) ? FRAME_LAST : frame_q - FRAME_WIDTH'(1);
            end
        end
        if (mmio_we) begin
            case (off)
                3'd1: led_d = dataIn[LED_WIDTH-1:0];
                3'd2: begin
                    frame_d = ({1'b0, dataIn} >= NF) ? FRAME_LAST : dataIn[FRAME_WIDTH-1:0];
                    pcnt_d  = '0;
                end
                3'd4: begin
                    auto_en_d = dataIn[0];
                    dir_d     = dataIn[1];
                end
                3'd5: begin
                    period_d = dataIn[PERIOD_WIDTH-1:0];
                    pcnt_d   = '0;
                end
                default: ;
            endcase
        end
    end

`ifdef MMIO_IRQ_EN
    logic [NUM_BTN-1:0] mask_q, mask_d;
    logic               irq_q, irq_d;

    assign mask_d = (mmio_we && off == 3'd6) ? dataIn[NUM_BTN-1:0] : mask_q;
    assign irq_d  = |(edge_q & mask_q);
    assign irq    = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            dbcnt_q   <= '0;
            edge_q    <= '0;
            led_q     <= '0;
            frame_q   <= '0;
            period_q  <= '0;
            pcnt_q    <= '0;
            auto_en_q <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            dbcnt_q   <= dbcnt_d;
            edge_q    <= edge_d;
            led_q     <= led_d;
            frame_q   <= frame_d;
            period_q  <= period_d;
            pcnt_q    <= pcnt_d;
            auto_en_q <= auto_en_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (off)
            3'd0: mmio_rdata = 32'(stable_q);
            3'd1: mmio_rdata = 32'(led_q);
            3'd2: mmio_rdata = 32'(frame_q);
            3'd3: mmio_rdata = 32'(edge_q);
            3'd4: mmio_rdata = {30'b0, dir_q, auto_en_q};
            3'd5: mmio_rdata = 32'(period_q);
`ifdef MMIO_IRQ_EN
            3'd6: mmio_rdata = 32'(mask_q);
`endif
            default: ;
        endcase
    end

    assign dataOut   = hit ? mmio_rdata : ram_rdata;
    assign LED       = led_q;
    assign frame_idx = frame_q;
endmodule

// File: tb/tb_mmio_hub.sv
// tb/tb_mmio_hub.sv - directed self-checking bench for mmio_hub (DEBOUNCE_CYCLES=4, NUM_FRAMES=4).
module tb_mmio_hub;
`ifdef MMIO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [4:0]  btn;
    logic [15:0] LED;
    logic [7:0]  frame_idx;
    logic        irq;
    logic [31:0] v;
    int          total = 0;
    int          bad = 0;

    mmio_hub #(
        .ADDR_WIDTH(12), .MMIO_BASE(1000), .NUM_BTN(5), .LED_WIDTH(16),
        .FRAME_WIDTH(8), .NUM_FRAMES(4), .PERIOD_WIDTH(24), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wEn(wEn), .addr(addr), .dataIn(dataIn),
        .dataOut(dataOut), .btn(btn), .LED(LED), .frame_idx(frame_idx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wEn = 1'b1;
        addr = a;
        dataIn = d;
        @(posedge clk);
        #1;
        wEn = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        addr = a;
        #2;
        d = dataOut;
    endtask

    initial begin
        rst_n = 1'b0; wEn = 1'b0; addr = '0; dataIn = '0; btn = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // reset mid-run
        wr(12'd5, 32'h55AA1234);
        wr(12'd1001, 32'h77);
        chk("led_pre_rst", 32'(LED), 32'h77);
        #3 rst_n = 1'b0;
        #1 chk("led_async_rst", 32'(LED), 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            rd(12'(1000 + i), v);
            chk($sformatf("rst_rd_off%0d", i), v, 32'h0);
            cyc(1);
        end
        chk("rst_frame", 32'(frame_idx), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(12'd5, v);
        chk("ram5_kept", v, 32'h55AA1234);

        // window isolation
        cyc(1);
        wr(12'd1001, 32'h0000ABCD);
        chk("led_abcd", 32'(LED), 32'hABCD);
        chk("ram1001_untouched", 32'(dut.u_ram.mem[1001] != 32'hABCD), 32'h1);
        wr(12'd999, 32'h1234);
        rd(12'd999, v);
        chk("ram999", v, 32'h1234);
        wr(12'd1001, 32'hFFFFFFFF);
        rd(12'd1001, v);
        chk("led_hi_bits_zero", v, 32'h0000FFFF);
        wr(12'd1007, 32'h5);
        rd(12'd1007, v);
        chk("reserved_reads0", v, 32'h0);

        // debounce: 3-cycle glitch rejected
        cyc(1);
        btn = 5'h04;
        cyc(3);
        btn = 5'h00;
        cyc(8);
        rd(12'd1000, v);
        chk("glitch_state", v, 32'h0);
        rd(12'd1003, v);
        chk("glitch_edge", v, 32'h0);

        // clean press: accepted 6 cycles after the change
        cyc(1);
        btn = 5'h04;
        cyc(5);
        rd(12'd1000, v);
        chk("db_cycle5", v, 32'h0);
        cyc(1);
        rd(12'd1000, v);
        chk("db_cycle6_state", v, 32'h4);
        rd(12'd1003, v);
        chk("db_cycle6_edge", v, 32'h4);
        wr(12'd1000, 32'h1F);
        rd(12'd1000, v);
        chk("btn_state_ro", v, 32'h4);
        btn = 5'h00;
        cyc(10);
        rd(12'd1003, v);
        chk("edge_sticky", v, 32'h4);
        wr(12'd1003, 32'h4);
        rd(12'd1003, v);
        chk("edge_w1c", v, 32'h0);

        // W1C coinciding with a new rising edge: set wins
        cyc(1);
        btn = 5'h04;
        cyc(5);
        wr(12'd1003, 32'h4);
        rd(12'd1003, v);
        chk("set_beats_w1c", v, 32'h4);
        rd(12'd1000, v);
        chk("state_after_w1c", v, 32'h4);
        wr(12'd1003, 32'h4);
        btn = 5'h00;
        cyc(10);

        // irq path
        wr(12'd1006, 32'h1);
        rd(12'd1006, v);
        chk("irq_mask_rd", v, IRQ_ON ? 32'h1 : 32'h0);
        cyc(1);
        btn = 5'h01;
        cyc(6);
        rd(12'd1003, v);
        chk("btn0_edge", v, 32'h1);
        chk("irq_same_cycle", 32'(irq), 32'h0);
        cyc(1);
        chk("irq_next_cycle", 32'(irq), 32'(IRQ_ON));
        wr(12'd1003, 32'h1);
        chk("irq_during_clear", 32'(irq), 32'(IRQ_ON));
        cyc(1);
        chk("irq_after_clear", 32'(irq), 32'h0);
        btn = 5'h00;
        cyc(10);

        // auto-advance increment with wrap
        wr(12'd1005, 32'd3);
        wr(12'd1004, 32'h1);
        cyc(2);
        chk("step_not_yet", 32'(frame_idx), 32'h0);
        cyc(1);
        chk("step1", 32'(frame_idx), 32'h1);
        cyc(3);
        chk("step2", 32'(frame_idx), 32'h2);
        cyc(3);
        chk("step3", 32'(frame_idx), 32'h3);
        cyc(3);
        chk("step_wrap0", 32'(frame_idx), 32'h0);

        // decrement wraps 0 -> 3
        wr(12'd1004, 32'h3);
        cyc(1);
        chk("dec_not_yet", 32'(frame_idx), 32'h0);
        cyc(1);
        chk("dec_wrap3", 32'(frame_idx), 32'h3);
        rd(12'd1004, v);
        chk("ctrl_rd", v, 32'h3);
        rd(12'd1005, v);
        chk("period_rd", v, 32'h3);

        // frame write on a tick cycle wins and restarts the period
        wr(12'd1004, 32'h1);
        cyc(1);
        wr(12'd1002, 32'd2);
        chk("write_beats_tick", 32'(frame_idx), 32'h2);
        cyc(2);
        chk("restart_hold", 32'(frame_idx), 32'h2);
        cyc(1);
        chk("restart_step", 32'(frame_idx), 32'h3);

        // saturation and hold
        wr(12'd1002, 32'd9);
        chk("frame_sat", 32'(frame_idx), 32'h3);
        rd(12'd1002, v);
        chk("frame_sat_rd", v, 32'h3);
        wr(12'd1004, 32'h0);
        cyc(10);
        chk("frame_static", 32'(frame_idx), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
